// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator.
// FSM states, next-PC select encoding and instruction size.
package pc_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_RET,
    SEL_HOLD,
    SEL_SEQ
  } sel_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count.
// A push when full overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [CW-1:0]   count;

  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);
  assign top     = mem[ptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      ptr          <= ptr_inc;
      mem[ptr_inc] <= data;
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CW'(1);
    end else if (replace) begin
      mem[ptr] <= data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential, stall, redirect,
// trap and return-prediction next-PC selection.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            ras_underflow,
  output logic            ras_empty,
  output logic            ras_full
);

  state_t          state;
  state_t          state_next;
  sel_t            sel;
  logic            run;
  logic            keep;
  logic            ras_clear;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_replace;
  logic            mis_next;
  logic            unf_next;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] pc_next;

  assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_valid = (state == RUN);
    run      = (state == RUN);
  end

  // Stall sits above ret so a stalled cycle never touches the RAS.
  always_comb begin
    sel = SEL_SEQ;
    if (trap_valid) begin
      sel = SEL_TRAP;
    end else if (redirect_valid) begin
      sel = SEL_REDIR;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = SEL_RET;
    end
  end

  always_comb begin
    keep        = run && (sel == SEL_RET || sel == SEL_SEQ);
    ras_clear   = run && (sel == SEL_TRAP);
    ras_replace = keep && call && ret && !ras_empty;
    ras_pop     = keep && !call && ret && !ras_empty;
    ras_push    = keep && call && (!ret || ras_empty);
    unf_next    = keep && ret && ras_empty;
    mis_next    = run && (sel == SEL_REDIR) &&
                  (redirect_target[1:0] != 2'b00);
  end

  always_comb begin
    pc_next = pc_plus4;
    unique case (sel)
      SEL_TRAP:  pc_next = trap_target;
      SEL_REDIR: pc_next = (redirect_target[1:0] != 2'b00) ?
                           TRAP_VECTOR : redirect_target;
      SEL_RET:   pc_next = ras_empty ? pc_plus4 : ras_top;
      SEL_HOLD:  pc_next = pc;
      SEL_SEQ:   pc_next = pc_plus4;
      default:   pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_VECTOR;
      misaligned    <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (run) begin
        pc <= pc_next;
      end
      misaligned    <= mis_next;
      ras_underflow <= unf_next;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ras_clear),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .data    (pc_plus4),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed vectors queue expected
// state, a monitor pops and compares after each update.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misaligned;
  logic        ras_underflow;
  logic        ras_empty;
  logic        ras_full;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        m;
    logic        u;
    logic        e;
    logic        f;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  pc_gen dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .pc_valid        (pc_valid),
    .misaligned      (misaligned),
    .ras_underflow   (ras_underflow),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        logic [31:0] p4;
        e  = sb.pop_front();
        p4 = e.pc + 32'd4;
        checks++;
        if (pc !== e.pc || pc_plus4 !== p4 || pc_valid !== e.v ||
            misaligned !== e.m || ras_underflow !== e.u ||
            ras_empty !== e.e || ras_full !== e.f) begin
          failures++;
          $display("FAIL %s: got pc=%h p4=%h v=%b mis=%b unf=%b emp=%b full=%b, want pc=%h p4=%h v=%b mis=%b unf=%b emp=%b full=%b",
                   e.name, pc, pc_plus4, pc_valid, misaligned,
                   ras_underflow, ras_empty, ras_full,
                   e.pc, p4, e.v, e.m, e.u, e.e, e.f);
        end
      end
    end
  end

  task automatic clr;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_target     = '0;
    call            = 1'b0;
    ret             = 1'b0;
  endtask

  task automatic step(input logic [31:0] p, input logic v,
                      input logic m, input logic u,
                      input logic e, input logic f,
                      input string n);
    exp_t x;
    x.pc = p; x.v = v; x.m = m; x.u = u; x.e = e; x.f = f;
    x.name = n;
    sb.push_back(x);
    @(negedge clk);
    clr();
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
  endtask

  task automatic async_rst;
    exp_t x;
    #2;
    x.pc = 32'h0; x.v = 0; x.m = 0; x.u = 0; x.e = 1; x.f = 0;
    x.name = "async_reset";
    sb.push_back(x);
    reset_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(32'h0, 0, 0, 0, 1, 0, "reset");
    reset_n = 1'b1;
    step(32'h0, 1, 0, 0, 1, 0, "boot_exit");
    step(32'h4, 1, 0, 0, 1, 0, "seq_4");
    step(32'h8, 1, 0, 0, 1, 0, "seq_8");
    redir(32'h40);
    step(32'h40, 1, 0, 0, 1, 0, "redir_40");
    async_rst();
    step(32'h0, 0, 0, 0, 1, 0, "reset_hold");
    reset_n = 1'b1;
    step(32'h0, 1, 0, 0, 1, 0, "boot2_exit");
    step(32'h4, 1, 0, 0, 1, 0, "seq2_4");
    step(32'h8, 1, 0, 0, 1, 0, "seq2_8");
    step(32'hC, 1, 0, 0, 1, 0, "seq2_c");
    step(32'h10, 1, 0, 0, 1, 0, "seq2_10");
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      step(32'h10, 1, 0, 0, 1, 0, "stall_hold");
    end
    stall = 1'b1; redir(32'h80);
    step(32'h80, 1, 0, 0, 1, 0, "stall_redir");
    redir(32'h82);
    step(32'h100, 1, 1, 0, 1, 0, "misaligned");
    step(32'h104, 1, 0, 0, 1, 0, "mis_clear");
    trap_valid = 1'b1; trap_target = 32'h200; redir(32'h300);
    step(32'h200, 1, 0, 0, 1, 0, "trap_over_redir");
    // five calls into a depth-4 stack
    redir(32'h0);
    step(32'h0, 1, 0, 0, 1, 0, "goto_0");
    call = 1'b1;
    step(32'h4, 1, 0, 0, 0, 0, "call1");
    redir(32'h10);
    step(32'h10, 1, 0, 0, 0, 0, "goto_10");
    call = 1'b1;
    step(32'h14, 1, 0, 0, 0, 0, "call2");
    redir(32'h20);
    step(32'h20, 1, 0, 0, 0, 0, "goto_20");
    call = 1'b1;
    step(32'h24, 1, 0, 0, 0, 0, "call3");
    redir(32'h30);
    step(32'h30, 1, 0, 0, 0, 0, "goto_30");
    call = 1'b1;
    step(32'h34, 1, 0, 0, 0, 1, "call4_full");
    redir(32'h40);
    step(32'h40, 1, 0, 0, 0, 1, "goto_40");
    call = 1'b1;
    step(32'h44, 1, 0, 0, 0, 1, "call5_wrap");
    ret = 1'b1;
    step(32'h44, 1, 0, 0, 0, 0, "ret1");
    ret = 1'b1;
    step(32'h34, 1, 0, 0, 0, 0, "ret2");
    ret = 1'b1;
    step(32'h24, 1, 0, 0, 0, 0, "ret3");
    ret = 1'b1;
    step(32'h14, 1, 0, 0, 1, 0, "ret4");
    ret = 1'b1;
    step(32'h18, 1, 0, 1, 1, 0, "underflow");
    step(32'h1C, 1, 0, 0, 1, 0, "unf_clear");
    redir(32'h20);
    step(32'h20, 1, 0, 0, 1, 0, "goto_20b");
    call = 1'b1;
    step(32'h24, 1, 0, 0, 0, 0, "push_24");
    redir(32'h50);
    step(32'h50, 1, 0, 0, 0, 0, "goto_50");
    call = 1'b1; ret = 1'b1;
    step(32'h24, 1, 0, 0, 0, 0, "call_ret");
    ret = 1'b1;
    step(32'h54, 1, 0, 0, 1, 0, "ret_replaced");
    call = 1'b1; ret = 1'b1;
    step(32'h58, 1, 0, 1, 0, 0, "call_ret_empty");
    ret = 1'b1;
    step(32'h58, 1, 0, 0, 1, 0, "ret_pushed");
    call = 1'b1;
    step(32'h5C, 1, 0, 0, 0, 0, "push_5c");
    trap_valid = 1'b1; trap_target = 32'h200;
    step(32'h200, 1, 0, 0, 1, 0, "trap_clear");
    ret = 1'b1;
    step(32'h204, 1, 0, 1, 1, 0, "ret_after_trap");
    stall = 1'b1; call = 1'b1;
    step(32'h204, 1, 0, 0, 1, 0, "stall_call");
    stall = 1'b1; ret = 1'b1;
    step(32'h204, 1, 0, 0, 1, 0, "stall_ret");
    redir(32'hFFFF_FFFC);
    step(32'hFFFF_FFFC, 1, 0, 0, 1, 0, "goto_top");
    step(32'h0, 1, 0, 0, 1, 0, "wrap");
    step(32'h4, 1, 0, 0, 1, 0, "wrap_seq");
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
